// File: rtl/alu_pkg.sv
// Shared opcodes and widths for the registered ALU slice.
// Optional zero flag output is enabled with the ALU_ZERO_FLAG_EN macro.
package alu_pkg;

  localparam int ALU_WIDTH = 4;
  localparam int RES_W     = 2 * ALU_WIDTH;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

endpackage

// File: rtl/alu_if.sv
// Operand/opcode/result bundle between control logic and the ALU.
// o_zero exists only when ALU_ZERO_FLAG_EN is defined.
interface alu_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);

  logic [WIDTH-1:0]   A_i;
  logic [WIDTH-1:0]   B_i;
  logic [2:0]         opSel;
  logic [2*WIDTH-1:0] o_alu;
`ifdef ALU_ZERO_FLAG_EN
  logic               o_zero;
`endif

`ifdef ALU_ZERO_FLAG_EN
  modport master (output A_i, B_i, opSel, input o_alu, o_zero);
  modport slave  (input A_i, B_i, opSel, output o_alu, o_zero);
`else
  modport master (output A_i, B_i, opSel, input o_alu);
  modport slave  (input A_i, B_i, opSel, output o_alu);
`endif

endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: operands and opcode in, next 2*WIDTH result out.
// Operands are unsigned and zero-extended before every operation.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op_sel,
  output logic [2*WIDTH-1:0] res
);

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;

  assign a_ext = {{WIDTH{1'b0}}, a};
  assign b_ext = {{WIDTH{1'b0}}, b};

  // Working at full result width keeps the ADD carry, the full MUL product
  // and the SUB borrow wrap without any extra sizing.
  always_comb begin
    res = '0;
    case (op_sel)
      OP_ADD: res = a_ext + b_ext;
      OP_SUB: res = a_ext - b_ext;
      OP_MUL: res = a_ext * b_ext;
      OP_AND: res = a_ext & b_ext;
      OP_OR:  res = a_ext | b_ext;
      OP_XOR: res = a_ext ^ b_ext;
      OP_SHL: res = a_ext << b[2:0];
      OP_CMP: begin
        res[2] = (a > b);
        res[1] = (a == b);
        res[0] = (a < b);
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered ALU top: one output register stage behind alu_core.
// Define ALU_ZERO_FLAG_EN to add the registered o_zero flag.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic  clk_i,
  input  logic  rst_i,
  alu_if.slave  bus
);

  logic [2*WIDTH-1:0] res_p0;
  logic [2*WIDTH-1:0] alu_p1;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (bus.A_i),
    .b      (bus.B_i),
    .op_sel (bus.opSel),
    .res    (res_p0)
  );

  // p0 -> p1: result register; reset clears the visible result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alu_p1 <= '0;
    end else begin
      alu_p1 <= res_p0;
    end
  end

  assign bus.o_alu = alu_p1;

`ifdef ALU_ZERO_FLAG_EN
  logic zero_p1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      zero_p1 <= 1'b1;
    end else begin
      zero_p1 <= (res_p0 == '0);
    end
  end

  assign bus.o_zero = zero_p1;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus a full opcode/operand sweep.
// Build with ALU_ZERO_FLAG_EN defined to also check o_zero.
module tb_alu;
  import alu_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;

  alu_if #(.WIDTH(4)) bus ();

  alu #(.WIDTH(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  // Independent reference written with integer arithmetic.
  function automatic logic [7:0] golden(input int a, input int b, input int op);
    int r;
    case (op)
      0: r = a + b;
      1: begin
        r = a - b;
        if (r < 0) r = r + 256;
      end
      2: r = a * b;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = (a * (1 << (b % 8))) % 256;
      default: begin
        if (a > b)       r = 4;
        else if (a == b) r = 2;
        else             r = 1;
      end
    endcase
    return r[7:0];
  endfunction

  // Drive one operation, record its expected result, and step past the edge.
  task automatic drive(input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input logic r);
    bus.A_i   = a;
    bus.B_i   = b;
    bus.opSel = op;
    rst_i     = r;
    exp_q.push_back(r ? 8'h00 : golden(int'(a), int'(b), int'(op)));
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(4'hF, 4'hF, OP_MUL, 1'b1);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (bus.o_alu !== exp_v) begin
        n_fails++;
        $display("FAIL reset_o_alu[%0d]: got %h expected %h", i, bus.o_alu, exp_v);
      end
`ifdef ALU_ZERO_FLAG_EN
      n_checks++;
      if (bus.o_zero !== 1'b1) begin
        n_fails++;
        $display("FAIL reset_o_zero[%0d]: got %b expected 1", i, bus.o_zero);
      end
`endif
    end
  endtask

  task automatic test_add_sub();
    logic [7:0] req[3] = '{8'h1E, 8'hFE, 8'h02};
    drive(4'hF, 4'hF, OP_ADD, 1'b0);
    drive(4'h3, 4'h5, OP_SUB, 1'b0);
    drive(4'h5, 4'h3, OP_SUB, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_v = exp_q.pop_front();
      n_checks += 2;
      if (exp_v !== req[i]) begin
        n_fails++;
        $display("FAIL add_sub_model[%0d]: model %h required %h", i, exp_v, req[i]);
      end
    end
    // Results checked one at a time to observe each registered value.
    drive(4'hF, 4'hF, OP_ADD, 1'b0);
    exp_v = exp_q.pop_front();
    if (bus.o_alu !== exp_v) begin
      n_fails++;
      $display("FAIL add_max: got %h expected %h", bus.o_alu, exp_v);
    end
    drive(4'h3, 4'h5, OP_SUB, 1'b0);
    exp_v = exp_q.pop_front();
    if (bus.o_alu !== exp_v) begin
      n_fails++;
      $display("FAIL sub_wrap: got %h expected %h", bus.o_alu, exp_v);
    end
    drive(4'h5, 4'h3, OP_SUB, 1'b0);
    exp_v = exp_q.pop_front();
    if (bus.o_alu !== exp_v) begin
      n_fails++;
      $display("FAIL sub_pos: got %h expected %h", bus.o_alu, exp_v);
    end
  endtask

  task automatic test_mul_logic();
    logic [3:0] a_t[4]  = '{4'hF, 4'hC, 4'hC, 4'hC};
    logic [3:0] b_t[4]  = '{4'hF, 4'hA, 4'hA, 4'hA};
    logic [2:0] op_t[4] = '{OP_MUL, OP_AND, OP_OR, OP_XOR};
    logic [7:0] req[4]  = '{8'hE1, 8'h08, 8'h0E, 8'h06};
    for (int i = 0; i < 4; i++) begin
      drive(a_t[i], b_t[i], op_t[i], 1'b0);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (bus.o_alu !== req[i] || bus.o_alu !== exp_v) begin
        n_fails++;
        $display("FAIL mul_logic[%0d]: got %h expected %h", i, bus.o_alu, req[i]);
      end
    end
  endtask

  task automatic test_shl_cmp();
    logic [3:0] a_t[4]  = '{4'h1, 4'h9, 4'h4, 4'h2};
    logic [3:0] b_t[4]  = '{4'h7, 4'hF, 4'h4, 4'h9};
    logic [2:0] op_t[4] = '{OP_SHL, OP_SHL, OP_CMP, OP_CMP};
    logic [7:0] req[4]  = '{8'h80, 8'h80, 8'h02, 8'h01};
    for (int i = 0; i < 4; i++) begin
      drive(a_t[i], b_t[i], op_t[i], 1'b0);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (bus.o_alu !== req[i] || bus.o_alu !== exp_v) begin
        n_fails++;
        $display("FAIL shl_cmp[%0d]: got %h expected %h", i, bus.o_alu, req[i]);
      end
    end
  endtask

  task automatic test_back_to_back_sweep();
    logic [10:0] vec;
    logic        r;
    for (int i = 0; i < 2048; i++) begin
      vec = i[10:0];
      r   = (i == 1000);
      drive(vec[3:0], vec[7:4], vec[10:8], r);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (bus.o_alu !== exp_v) begin
        n_fails++;
        $display("FAIL sweep[%0d]: o_alu got %h expected %h", i, bus.o_alu, exp_v);
      end
`ifdef ALU_ZERO_FLAG_EN
      n_checks++;
      if (bus.o_zero !== (exp_v == 8'h00)) begin
        n_fails++;
        $display("FAIL sweep_zero[%0d]: o_zero got %b expected %b", i, bus.o_zero,
                 (exp_v == 8'h00));
      end
`endif
    end
  endtask

`ifdef ALU_ZERO_FLAG_EN
  task automatic test_zero_flag();
    drive(4'h5, 4'h5, OP_SUB, 1'b0);
    exp_v = exp_q.pop_front();
    n_checks += 2;
    if (bus.o_alu !== 8'h00 || bus.o_alu !== exp_v) begin
      n_fails++;
      $display("FAIL zero_alu: got %h expected 00", bus.o_alu);
    end
    if (bus.o_zero !== 1'b1) begin
      n_fails++;
      $display("FAIL zero_set: got %b expected 1", bus.o_zero);
    end
    drive(4'h5, 4'h4, OP_SUB, 1'b0);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (bus.o_zero !== 1'b0) begin
      n_fails++;
      $display("FAIL zero_clr: got %b expected 0 (o_alu %h)", bus.o_zero, bus.o_alu);
    end
  endtask
`endif

  initial begin
    rst_i     = 1'b1;
    bus.A_i   = '0;
    bus.B_i   = '0;
    bus.opSel = '0;
    #2;
    test_reset();
    test_add_sub();
    test_mul_logic();
    test_shl_cmp();
    test_back_to_back_sweep();
`ifdef ALU_ZERO_FLAG_EN
    test_zero_flag();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
